adder_vector_checker: RTL and testbench
=======================================

Name: adder_vector_checker

Overview:
- Synthesizable scoreboard stage sitting directly downstream of the adder DUV and the reference adder in the adder test environment.
- Consumes one applied vector per valid cycle: operands plus both sets of results.
- Compares DUV against reference, counts vectors and mismatches, captures the first failing vector and reports pass/fail at end of run.
- Replaces the free-running comparator with a bounded, start/done-controlled checker usable for all widths and adder types.

Parameters:
- N, 8, adder operand width.
- TYPE, 0, 0 = adder has no prop/gen outputs (csa, cra, a1csa); 1 = prop/gen compared (cla, a1csah).
- NUM_VECTORS, 30000, vectors per run; must be ≥1 and < 2**CNT_W.
- CNT_W, 16, width of the vector and error counters.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- vec_valid  in  1  current inputs/results form one vector to check.
- cin  in  1  applied carry-in.
- a, b  in  N  applied operands.
- s_ref, s_duv  in  N  reference and DUV sums.
- cout_ref, cout_duv  in  1  reference and DUV carry-out.
- prop_ref, gen_ref, prop_duv, gen_duv  in  1  group propagate/generate; ignored when TYPE=0.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid while done: 1 iff err_count==0.
- mismatch  out  1  one-cycle pulse, one cycle after a failing vector.
- vec_count  out  CNT_W  vectors accepted this run.
- err_count  out  CNT_W  failing vectors this run; saturates.
- err_valid  out  1  first-error capture registers hold data.
- first_err_a, first_err_b  out  N  operands of first failing vector.
- first_err_cin  out  1  carry-in of first failing vector.
- first_err_flags  out  4  {gen,prop,cout,sum} mismatch bits of first failing vector.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0.
- States:
  - IDLE: start → RUN.
  - RUN: the accepting vector that brings vec_count to NUM_VECTORS → DONE in the same edge.
  - DONE: start → RUN.
  - start in RUN is ignored.
- Entering RUN clears vec_count, err_count, err_valid, first_err_* and pass in the same edge. done=0 and busy=1 from the next cycle.
- Acceptance: only when state==RUN && vec_valid. vec_valid in IDLE/DONE is ignored; no counters change.
- Compare (combinational per accepted vector):
  - flags[0] = (s_duv != s_ref)
  - flags[1] = (cout_duv != cout_ref)
  - flags[2] = TYPE ? (prop_duv != prop_ref) : 0
  - flags[3] = TYPE ? (gen_duv != gen_ref) : 0
  - fail = |flags
- Latency: vec_count, err_count, mismatch and first-error capture update on the edge that accepts the vector (mismatch visible the following cycle, 1 cycle wide).
- err_count saturates at 2**CNT_W−1; the mismatch pulse still fires.
- First-error capture: loads only when fail && !err_valid; err_valid is then set. Later failures do not overwrite it.
- DONE: done=1, busy=0, pass=(err_count==0). Counters and capture registers hold until the next start or reset.
- Start coincident with vec_valid in IDLE/DONE: the vector is not accepted; counting begins next cycle.
- Reset mid-RUN: immediate return to IDLE with everything cleared; no partial result is reported.
- X/Z on compared inputs counts as a mismatch in simulation (use case-inequality in the compare).

Decomposition:
- Shared package adder_tb_pkg:
  - state enum {IDLE, RUN, DONE}
  - flag bit index constants FLG_SUM=0, FLG_COUT=1, FLG_PROP=2, FLG_GEN=3
  - TYPE encodings TYPE_RIPPLE=0, TYPE_LOOKAHEAD=1
- One natural sub-module: adder_result_compare (combinational; parameters N, TYPE; outputs flags[3:0] and fail).
- FSM, counters and capture logic stay in adder_vector_checker.

Test Plan:
- Reset then start, 30000 vectors with s_duv=s_ref, cout_duv=cout_ref, vec_valid=1 → DONE after exactly 30000 accepts; vec_count=30000, err_count=0, pass=1, err_valid=0.
- NUM_VECTORS=4, 2nd vector a=8'h0F, b=8'h01, cin=0, s_duv=8'h00 vs s_ref=8'h10 → mismatch pulse once; err_count=1; first_err_a=0x0F, first_err_b=0x01, first_err_flags=4'b0001; pass=0 at done.
- TYPE=0 with prop_duv≠prop_ref on every vector, sums/couts equal → err_count=0, pass=1. Same stimulus with TYPE=1 → err_count=NUM_VECTORS, first_err_flags=4'b0100.
- Vectors 3 (cout wrong) and 5 (sum wrong) fail → first_err_flags=4'b0010, captured from vector 3, unchanged after vector 5; err_count=2.
- CNT_W=4, NUM_VECTORS=15, all vectors fail → err_count=15 (saturated), mismatch pulsed 15 times. Start in DONE with vec_valid=1 → counters cleared, that vector not counted.
- rst_n low for 1 cycle after vector 100 of a run → all outputs 0 asynchronously, state IDLE; vec_valid ignored until the next start.

Source files
------------

// File: rtl/adder_tb_pkg.sv
// rtl/adder_tb_pkg.sv - shared types and constants for the adder vector checker
package adder_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLG_SUM  = 0;
  localparam int FLG_COUT = 1;
  localparam int FLG_PROP = 2;
  localparam int FLG_GEN  = 3;

  localparam int TYPE_RIPPLE    = 0;
  localparam int TYPE_LOOKAHEAD = 1;

endpackage

// File: rtl/adder_result_compare.sv
// rtl/adder_result_compare.sv - combinational DUV vs reference result compare
module adder_result_compare
  import adder_tb_pkg::*;
#(
  parameter int N    = 8,
  parameter int TYPE = TYPE_RIPPLE
) (
  input  logic [N-1:0] s_ref,
  input  logic [N-1:0] s_duv,
  input  logic         cout_ref,
  input  logic         cout_duv,
  input  logic         prop_ref,
  input  logic         gen_ref,
  input  logic         prop_duv,
  input  logic         gen_duv,
  output logic [3:0]   flags,
  output logic         fail
);

  // Case-inequality so X/Z from a broken DUV is flagged rather than masked.
  always_comb begin
    flags           = '0;
    flags[FLG_SUM]  = (s_duv !== s_ref);
    flags[FLG_COUT] = (cout_duv !== cout_ref);
    flags[FLG_PROP] = (TYPE == TYPE_LOOKAHEAD) && (prop_duv !== prop_ref);
    flags[FLG_GEN]  = (TYPE == TYPE_LOOKAHEAD) && (gen_duv !== gen_ref);
  end

  assign fail = |flags;

endmodule

// File: rtl/adder_vector_checker.sv
// rtl/adder_vector_checker.sv - bounded start/done scoreboard for adder DUV results
module adder_vector_checker
  import adder_tb_pkg::*;
#(
  parameter int N           = 8,
  parameter int TYPE        = 0,
  parameter int NUM_VECTORS = 30000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             cin,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     s_ref,
  input  logic [N-1:0]     s_duv,
  input  logic             cout_ref,
  input  logic             cout_duv,
  input  logic             prop_ref,
  input  logic             gen_ref,
  input  logic             prop_duv,
  input  logic             gen_duv,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_valid,
  output logic [N-1:0]     first_err_a,
  output logic [N-1:0]     first_err_b,
  output logic             first_err_cin,
  output logic [3:0]       first_err_flags
);

  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

  state_t     state;
  state_t     state_nxt;
  logic [3:0] flags;
  logic       fail;
  logic       accept;
  logic       clear;

  adder_result_compare #(
    .N    (N),
    .TYPE (TYPE)
  ) u_compare (
    .s_ref    (s_ref),
    .s_duv    (s_duv),
    .cout_ref (cout_ref),
    .cout_duv (cout_duv),
    .prop_ref (prop_ref),
    .gen_ref  (gen_ref),
    .prop_duv (prop_duv),
    .gen_duv  (gen_duv),
    .flags    (flags),
    .fail     (fail)
  );

  assign accept = (state == RUN) && vec_valid;
  assign clear  = (state != RUN) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && (vec_count == LAST_VEC)) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    pass = (state == DONE) && (err_count == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count       <= '0;
      err_count       <= '0;
      mismatch        <= 1'b0;
      err_valid       <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_cin   <= 1'b0;
      first_err_flags <= '0;
    end else if (clear) begin
      vec_count       <= '0;
      err_count       <= '0;
      mismatch        <= 1'b0;
      err_valid       <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_cin   <= 1'b0;
      first_err_flags <= '0;
    end else if (accept) begin
      vec_count <= vec_count + 1'b1;
      mismatch  <= fail;
      if (fail && (err_count != ERR_MAX)) begin
        err_count <= err_count + 1'b1;
      end
      // Only the first failure of a run is kept for debug.
      if (fail && !err_valid) begin
        err_valid       <= 1'b1;
        first_err_a     <= a;
        first_err_b     <= b;
        first_err_cin   <= cin;
        first_err_flags <= flags;
      end
    end else begin
      mismatch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_vector_checker.sv
// tb/tb_adder_vector_checker.sv - randomized self-checking bench for adder_vector_checker
module tb_adder_vector_checker;

  localparam int NVS  [4] = '{30000, 6, 6, 15};
  localparam int TYP  [4] = '{0, 0, 1, 1};
  localparam int EMAX [4] = '{65535, 65535, 65535, 15};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i [4];
  logic       vec_valid, cin;
  logic [7:0] a, b, s_ref, s_duv;
  logic       cout_ref, cout_duv, prop_ref, gen_ref, prop_duv, gen_duv;
  logic       e_sum, e_cout, e_prop, e_gen;

  logic        busy_o [4], done_o [4], pass_o [4], mm_o [4], ev_o [4], fc_o [4];
  logic [7:0]  fa_o [4], fb_o [4];
  logic [3:0]  ff_o [4];
  logic [15:0] vc_o [3], ec_o [3];
  logic [3:0]  vc3, ec3;

  int         m_vc [4], m_ec [4], pulses [4];
  bit         m_run [4], m_done [4], m_mm [4], m_ev [4], m_fc [4];
  logic [7:0] m_fa [4], m_fb [4];
  logic [3:0] m_ff [4];
  int         tests = 0, fails = 0;
  int         guard;
  logic [7:0] a_keep;

  always #5 clk = ~clk;

  adder_vector_checker #(.N(8), .TYPE(0), .NUM_VECTORS(30000), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .vec_valid(vec_valid), .cin(cin), .a(a), .b(b),
    .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv), .prop_ref(prop_ref),
    .gen_ref(gen_ref), .prop_duv(prop_duv), .gen_duv(gen_duv), .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .mismatch(mm_o[0]), .vec_count(vc_o[0]), .err_count(ec_o[0]), .err_valid(ev_o[0]),
    .first_err_a(fa_o[0]), .first_err_b(fb_o[0]), .first_err_cin(fc_o[0]), .first_err_flags(ff_o[0]));

  adder_vector_checker #(.N(8), .TYPE(0), .NUM_VECTORS(6), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .vec_valid(vec_valid), .cin(cin), .a(a), .b(b),
    .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv), .prop_ref(prop_ref),
    .gen_ref(gen_ref), .prop_duv(prop_duv), .gen_duv(gen_duv), .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .mismatch(mm_o[1]), .vec_count(vc_o[1]), .err_count(ec_o[1]), .err_valid(ev_o[1]),
    .first_err_a(fa_o[1]), .first_err_b(fb_o[1]), .first_err_cin(fc_o[1]), .first_err_flags(ff_o[1]));

  adder_vector_checker #(.N(8), .TYPE(1), .NUM_VECTORS(6), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_i[2]), .vec_valid(vec_valid), .cin(cin), .a(a), .b(b),
    .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv), .prop_ref(prop_ref),
    .gen_ref(gen_ref), .prop_duv(prop_duv), .gen_duv(gen_duv), .busy(busy_o[2]), .done(done_o[2]),
    .pass(pass_o[2]), .mismatch(mm_o[2]), .vec_count(vc_o[2]), .err_count(ec_o[2]), .err_valid(ev_o[2]),
    .first_err_a(fa_o[2]), .first_err_b(fb_o[2]), .first_err_cin(fc_o[2]), .first_err_flags(ff_o[2]));

  adder_vector_checker #(.N(8), .TYPE(1), .NUM_VECTORS(15), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_i[3]), .vec_valid(vec_valid), .cin(cin), .a(a), .b(b),
    .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv), .prop_ref(prop_ref),
    .gen_ref(gen_ref), .prop_duv(prop_duv), .gen_duv(gen_duv), .busy(busy_o[3]), .done(done_o[3]),
    .pass(pass_o[3]), .mismatch(mm_o[3]), .vec_count(vc3), .err_count(ec3), .err_valid(ev_o[3]),
    .first_err_a(fa_o[3]), .first_err_b(fb_o[3]), .first_err_cin(fc_o[3]), .first_err_flags(ff_o[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vc_of(input int i);
    return (i == 3) ? {28'b0, vc3} : {16'b0, vc_o[i]};
  endfunction

  function automatic logic [31:0] ec_of(input int i);
    return (i == 3) ? {28'b0, ec3} : {16'b0, ec_o[i]};
  endfunction

  // Drives one vector; the reference is plain addition, the DUV copy gets the requested faults.
  task automatic set_vec(input logic v, input logic [7:0] va, input logic [7:0] vb, input logic vcin,
                         input logic es, input logic ec, input logic ep, input logic eg);
    logic [8:0] t, g;
    t = {1'b0, va} + {1'b0, vb} + {8'b0, vcin};
    g = {1'b0, va} + {1'b0, vb};
    vec_valid = v; a = va; b = vb; cin = vcin;
    s_ref = t[7:0]; cout_ref = t[8]; prop_ref = &(va ^ vb); gen_ref = g[8];
    s_duv = es ? (t[7:0] ^ 8'h10) : t[7:0];
    cout_duv = t[8] ^ ec; prop_duv = prop_ref ^ ep; gen_duv = gen_ref ^ eg;
    e_sum = es; e_cout = ec; e_prop = ep; e_gen = eg;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0; m_done[i] = 0; m_mm[i] = 0; m_vc[i] = 0; m_ec[i] = 0;
      m_ev[i] = 0; m_fa[i] = 8'h00; m_fb[i] = 8'h00; m_fc[i] = 0; m_ff[i] = 4'h0;
    end
  endtask

  task automatic model_edge(input int i);
    logic [3:0] fl;
    bit f, acc;
    fl  = {(TYP[i] != 0) && e_gen, (TYP[i] != 0) && e_prop, e_cout, e_sum};
    f   = (fl != 4'h0);
    acc = m_run[i] && vec_valid;
    m_mm[i] = acc && f;
    if (!m_run[i] && start_i[i]) begin
      m_run[i] = 1; m_done[i] = 0; m_vc[i] = 0; m_ec[i] = 0;
      m_ev[i] = 0; m_fa[i] = 8'h00; m_fb[i] = 8'h00; m_fc[i] = 0; m_ff[i] = 4'h0;
    end else if (acc) begin
      m_vc[i]++;
      if (f) begin
        if (m_ec[i] < EMAX[i]) m_ec[i]++;
        if (!m_ev[i]) begin
          m_ev[i] = 1; m_fa[i] = a; m_fb[i] = b; m_fc[i] = cin; m_ff[i] = fl;
        end
      end
      if (m_vc[i] == NVS[i]) begin
        m_run[i] = 0; m_done[i] = 1;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_busy", i), {31'b0, busy_o[i]}, {31'b0, m_run[i]});
      chk($sformatf("u%0d_done", i), {31'b0, done_o[i]}, {31'b0, m_done[i]});
      chk($sformatf("u%0d_pass", i), {31'b0, pass_o[i]}, {31'b0, m_done[i] && (m_ec[i] == 0)});
      chk($sformatf("u%0d_mismatch", i), {31'b0, mm_o[i]}, {31'b0, m_mm[i]});
      chk($sformatf("u%0d_vec_count", i), vc_of(i), 32'(m_vc[i]));
      chk($sformatf("u%0d_err_count", i), ec_of(i), 32'(m_ec[i]));
      chk($sformatf("u%0d_err_valid", i), {31'b0, ev_o[i]}, {31'b0, m_ev[i]});
      chk($sformatf("u%0d_first_a", i), {24'b0, fa_o[i]}, {24'b0, m_fa[i]});
      chk($sformatf("u%0d_first_b", i), {24'b0, fb_o[i]}, {24'b0, m_fb[i]});
      chk($sformatf("u%0d_first_cin", i), {31'b0, fc_o[i]}, {31'b0, m_fc[i]});
      chk($sformatf("u%0d_first_flags", i), {28'b0, ff_o[i]}, {28'b0, m_ff[i]});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) for (int i = 0; i < 4; i++) model_edge(i);
    #1;
    check_all();
    for (int i = 0; i < 4; i++) if (mm_o[i] === 1'b1) pulses[i]++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin start_i[i] = 1'b0; pulses[i] = 0; end
    model_reset();
    set_vec(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc();
    rst_n = 1'b1;

    // Long clean run on the TYPE=0 checker; prop/gen noise must be ignored.
    start_i[0] = 1'b1;
    set_vec(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    start_i[0] = 1'b0;
    guard = 0;
    while (m_run[0] && guard < 40000) begin
      set_vec(1'($urandom_range(7) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
              1'b0, 1'b0, 1'($urandom), 1'($urandom));
      cyc();
      guard++;
    end
    chk("big_timeout", {31'b0, guard < 40000}, 32'd1);
    chk("big_done", {31'b0, done_o[0]}, 32'd1);
    chk("big_vec_count", vc_of(0), 32'd30000);
    chk("big_err_count", ec_of(0), 32'd0);
    chk("big_pass", {31'b0, pass_o[0]}, 32'd1);
    chk("big_err_valid", {31'b0, ev_o[0]}, 32'd0);
    chk("idle_ignores_valid", vc_of(1), 32'd0);

    // Asynchronous reset after 100 accepted vectors.
    start_i[0] = 1'b1;
    set_vec(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    start_i[0] = 1'b0;
    guard = 0;
    while (m_vc[0] < 100 && guard < 1000) begin
      set_vec(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(3) == 0), 1'b0, 1'b0, 1'b0);
      cyc();
      guard++;
    end
    chk("rst_pre_count", vc_of(0), 32'd100);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    cyc();
    rst_n = 1'b1;
    repeat (5) begin
      set_vec(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    chk("rst_idle_count", vc_of(0), 32'd0);
    chk("rst_idle_busy", {31'b0, busy_o[0]}, 32'd0);

    // Run A: prop wrong on every vector, vector 2 has a wrong sum.
    start_i[1] = 1'b1; start_i[2] = 1'b1;
    set_vec(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    start_i[1] = 1'b0; start_i[2] = 1'b0;
    pulses[1] = 0; pulses[2] = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) set_vec(1'b1, 8'h0F, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      else        set_vec(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    set_vec(1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc();
    chk("runA_t0_err", ec_of(1), 32'd1);
    chk("runA_t0_pulses", 32'(pulses[1]), 32'd1);
    chk("runA_t0_first_a", {24'b0, fa_o[1]}, 32'h0F);
    chk("runA_t0_first_b", {24'b0, fb_o[1]}, 32'h01);
    chk("runA_t0_flags", {28'b0, ff_o[1]}, 32'b0001);
    chk("runA_t0_pass", {31'b0, pass_o[1]}, 32'd0);
    chk("runA_t1_err", ec_of(2), 32'd6);
    chk("runA_t1_flags", {28'b0, ff_o[2]}, 32'b0100);

    // Run B: restart from DONE with a coincident (uncounted) failing vector.
    start_i[1] = 1'b1; start_i[2] = 1'b1;
    set_vec(1'b1, 8'h55, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    start_i[1] = 1'b0; start_i[2] = 1'b0;
    chk("runB_start_vc", vc_of(1), 32'd0);
    chk("runB_start_ev", {31'b0, ev_o[1]}, 32'd0);
    a_keep = 8'h00;
    for (int k = 0; k < 6; k++) begin
      set_vec(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'(k == 4), 1'(k == 2), 1'b0, 1'b0);
      if (k == 2) a_keep = a;
      cyc();
    end
    chk("runB_t0_err", ec_of(1), 32'd2);
    chk("runB_t1_err", ec_of(2), 32'd2);
    chk("runB_flags", {28'b0, ff_o[2]}, 32'b0010);
    chk("runB_first_a", {24'b0, fa_o[1]}, {24'b0, a_keep});

    // Narrow counters: every vector fails.
    start_i[3] = 1'b1;
    set_vec(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    start_i[3] = 1'b0;
    pulses[3] = 0;
    guard = 0;
    while (m_run[3] && guard < 200) begin
      set_vec(1'($urandom_range(3) != 0), 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
      guard++;
    end
    set_vec(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("sat_err", ec_of(3), 32'd15);
    chk("sat_pulses", 32'(pulses[3]), 32'd15);
    chk("sat_pass", {31'b0, pass_o[3]}, 32'd0);
    start_i[3] = 1'b1;
    set_vec(1'b1, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    start_i[3] = 1'b0;
    chk("sat_restart_vc", vc_of(3), 32'd0);
    chk("sat_restart_err", ec_of(3), 32'd0);
    chk("sat_restart_busy", {31'b0, busy_o[3]}, 32'd1);
    cyc();
    chk("sat_next_vc", vc_of(3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
